serial_adder: RTL

- Bit-serial WIDTH-bit adder controller that time-shares one 1-bit full-adder cell over WIDTH clock cycles.
- The cell is built from two existing HalfAdder instances.
- Sits beside the combinational adder components as a low-area alternative.
- start/done handshake; operands captured on start, result held until the next start.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/HalfAdder.sv | 21 ++
 rtl/full_adder_ha.sv | 43 ++++
 rtl/serial_adder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice: the controller state
//   encoding and the default operand width.
//
//   Contents:
//     DEFAULT_WIDTH  default operand/result width (8)
//     state_t        controller states IDLE=0, RUN=1, DONE=2
// ----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/HalfAdder.sv
// ----------------------------------------------------------------------------
// HalfAdder
//   Existing 1-bit half-adder cell shared with the combinational adders.
//
//   Ports:
//     s  output  sum bit (a xor b)
//     c  output  carry bit (a and b)
//     a  input   operand bit
//     b  input   operand bit
// ----------------------------------------------------------------------------
module HalfAdder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : HalfAdder

// File: rtl/full_adder_ha.sv
// ----------------------------------------------------------------------------
// full_adder_ha
//   1-bit full adder built from two HalfAdder cells and an OR on the carries.
//   This is the only arithmetic in the serial adder; the controller reuses it
//   once per bit.
//
//   Ports:
//     s   output  sum bit
//     c   output  carry-out
//     a   input   operand bit
//     b   input   operand bit
//     ci  input   carry-in
// ----------------------------------------------------------------------------
module full_adder_ha (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic s0;
    logic c0;
    logic c1;

    HalfAdder u_ha0 (
        .s (s0),
        .c (c0),
        .a (a),
        .b (b)
    );

    HalfAdder u_ha1 (
        .s (s),
        .c (c1),
        .a (s0),
        .b (ci)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign c = c0 | c1;

endmodule : full_adder_ha

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. One full-adder cell is time-shared over WIDTH
//   clock cycles, LSB first. Operands are captured on an accepted start; the
//   result is held from the done pulse until the next accepted start.
//   Latency: start sampled at edge k -> done high after edge k+WIDTH.
//
//   Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input: when high
//   at an accepted start the block computes a-b (cout=1 means no borrow).
//
//   Parameters:
//     WIDTH  operand/result width, 2..32 (default 8)
//
//   Ports:
//     clk    input   rising-edge clock
//     rst    input   synchronous reset, active-high
//     start  input   request a new operation (ignored while busy)
//     a, b   input   operands, sampled on accepted start
//     cin    input   carry-in, sampled on accepted start
//     sub    input   subtract select (SERIAL_ADDER_SUB_EN builds only)
//     busy   output  high while the bit-serial loop is running
//     done   output  one-cycle pulse, sum/cout valid
//     sum    output  result (shows partial contents while busy)
//     cout   output  carry-out of the MSB
// ----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Subtraction is a + ~b + 1, so only the loaded operand and initial
    // carry change; the serial loop is identical.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b   : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign last_bit = (cnt == LAST_CNT);

    full_adder_ha u_fa (
        .s  (fa_s),
        .c  (fa_c),
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry)
    );

    // NOTE: registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, otherwise any
    // path that skips an assignment infers a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A start here is taken immediately, so back-to-back
                // operations lose no cycle.
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the datapath is a handful of flops, not a memory array, so all
    // of it is reset; an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            op_a   <= a;
            op_b   <= b_load;
            sum_q  <= '0;
            carry  <= carry_load;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            sum_q <= {fa_s, sum_q[WIDTH-1:1]};
            carry <= fa_c;
            // Counter parks on the last index rather than wrapping.
            if (last_bit) cout_q <= fa_c;
            else          cnt    <= cnt + CNT_W'(1);
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder
